// File: rtl/uart_rx_if.sv
// Serial receive bundle: pin and enable toward the receiver, byte and status pulses back.
interface uart_rx_if #(
  parameter int unsigned PAYLOAD_BITS = 8
);
  logic                    uart_rxd;
  logic                    uart_rx_en;
  logic                    uart_rx_valid;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic                    uart_rx_frame_err;
  logic                    uart_rx_break;

  modport master (
    output uart_rxd,
    output uart_rx_en,
    input  uart_rx_valid,
    input  uart_rx_data,
    input  uart_rx_frame_err,
    input  uart_rx_break
  );

  modport slave (
    input  uart_rxd,
    input  uart_rx_en,
    output uart_rx_valid,
    output uart_rx_data,
    output uart_rx_frame_err,
    output uart_rx_break
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: synchronises rxd, qualifies the start bit, samples mid-bit,
// and reports the byte, framing errors and line breaks as one-cycle pulses.
module uart_rx #(
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave rx
);

  localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int unsigned CNT_W          = $clog2(CYCLES_PER_BIT + 1);
  localparam int unsigned IDX_W          = $clog2(PAYLOAD_BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        bit_idx;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic                    rxd_m;
  logic                    rxd_s;
  logic                    valid_q;
  logic                    frame_err_q;
  logic                    break_q;
  logic [PAYLOAD_BITS-1:0] data_q;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rx.uart_rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
      if (!rx.uart_rx_en) begin
        state   <= IDLE;
        cnt     <= '0;
        bit_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt     <= '0;
            bit_idx <= '0;
            if (!rxd_s) state <= START;
          end
          // Re-check the line at mid start bit to reject glitches.
          START: begin
            if (cnt == CNT_W'(HALF_BIT - 1)) begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= rxd_s ? IDLE : DATA;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          DATA: begin
            if (cnt == CNT_W'(CYCLES_PER_BIT - 1)) begin
              cnt   <= '0;
              shreg <= {rxd_s, shreg[PAYLOAD_BITS-1:1]};
              if (bit_idx == IDX_W'(PAYLOAD_BITS - 1)) begin
                state <= STOP;
              end else begin
                bit_idx <= bit_idx + IDX_W'(1);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          STOP: begin
            if (cnt == CNT_W'(CYCLES_PER_BIT - 1)) begin
              cnt   <= '0;
              state <= IDLE;
              if (rxd_s) begin
                valid_q <= 1'b1;
                data_q  <= shreg;
              end else begin
                frame_err_q <= 1'b1;
                break_q     <= (shreg == '0);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign rx.uart_rx_valid     = valid_q;
  assign rx.uart_rx_data      = data_q;
  assign rx.uart_rx_frame_err = frame_err_q;
  assign rx.uart_rx_break     = break_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bit-banged frames, random traffic and a
// frame-level reference model compared against the outputs every cycle.
module tb_uart_rx;

  localparam int BIT_RATE = 10;
  localparam int CLK_HZ   = 160;
  localparam int PB       = 8;
  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int HALF     = CPB / 2;

  logic clk = 1'b0;
  logic reset;

  uart_rx_if #(.PAYLOAD_BITS(PB)) bus ();

  uart_rx #(
    .BIT_RATE    (BIT_RATE),
    .CLK_HZ      (CLK_HZ),
    .PAYLOAD_BITS(PB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  // Reference model: the line as the receiver sees it (two-cycle delay),
  // decoded by frame arithmetic on the age of the detected start edge.
  logic          m_d1 = 1'b1, m_d2 = 1'b1;
  bit            m_pending = 1'b0;
  bit            m_live = 1'b0;
  int            m_age = 0;
  logic [PB-1:0] m_bits = '0;
  logic          e_valid = 1'b0, e_ferr = 1'b0, e_brk = 1'b0;
  logic [PB-1:0] e_data = '0;

  always @(posedge clk) begin
    logic s;
    int   n;
    s       = m_d2;
    e_valid = 1'b0;
    e_ferr  = 1'b0;
    e_brk   = 1'b0;
    if (reset) begin
      m_d1      = 1'b1;
      m_d2      = 1'b1;
      m_pending = 1'b0;
      e_data    = '0;
      m_live    = 1'b1;
    end else begin
      m_d2 = m_d1;
      m_d1 = bus.uart_rxd;
      if (!bus.uart_rx_en) begin
        m_pending = 1'b0;
      end else if (!m_pending) begin
        if (!s) begin
          m_pending = 1'b1;
          m_age     = 0;
        end
      end else begin
        m_age++;
        if (m_age == HALF) begin
          if (s) m_pending = 1'b0;
        end else if (m_age > HALF && (m_age - HALF) % CPB == 0) begin
          n = (m_age - HALF) / CPB;
          if (n <= PB) begin
            m_bits[n-1] = s;
          end else begin
            if (s) begin
              e_valid = 1'b1;
              e_data  = m_bits;
            end else begin
              e_ferr = 1'b1;
              e_brk  = (m_bits == '0);
            end
            m_pending = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      checks++;
      if (bus.uart_rx_valid !== e_valid || bus.uart_rx_frame_err !== e_ferr ||
          bus.uart_rx_break !== e_brk || bus.uart_rx_data !== e_data) begin
        failures++;
        $display("FAIL cycle %0d: got valid/ferr/brk/data=%b/%b/%b/%h required %b/%b/%b/%h",
                 cyc, bus.uart_rx_valid, bus.uart_rx_frame_err, bus.uart_rx_break,
                 bus.uart_rx_data, e_valid, e_ferr, e_brk, e_data);
      end
    end
  end

  // Observed pulse counts and received bytes from the DUT.
  int            vcnt = 0, fcnt = 0, bcnt = 0;
  int            last_valid_cyc = 0;
  logic [PB-1:0] rx_q[$];

  always @(negedge clk) begin
    if (bus.uart_rx_valid === 1'b1) begin
      vcnt++;
      last_valid_cyc = cyc;
      rx_q.push_back(bus.uart_rx_data);
    end
    if (bus.uart_rx_frame_err === 1'b1) fcnt++;
    if (bus.uart_rx_break === 1'b1) bcnt++;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // All drives happen 1 time unit after a rising edge.
  task automatic drive(input logic v, input int n);
    bus.uart_rxd = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int start_cyc = 0;

  task automatic send_frame(input logic [PB-1:0] b, input logic stop, input int gap);
    start_cyc = cyc + 1;
    drive(1'b0, CPB);
    for (int i = 0; i < PB; i++) drive(b[i], CPB);
    drive(stop, CPB);
    if (gap > 0) drive(1'b1, gap);
  endtask

  logic [PB-1:0] sent_q[$];
  int            v0, f0, b0;
  logic [PB-1:0] rb;

  initial begin
    reset          = 1'b1;
    bus.uart_rxd   = 1'b1;
    bus.uart_rx_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_valid", int'(bus.uart_rx_valid), 0);
    chk("reset_data", int'(bus.uart_rx_data), 0);
    drive(1'b1, 10);

    // Single frame; latency 2 + 8 + 9*16 = 154 cycles at this bit rate.
    send_frame(8'hA5, 1'b1, 20);
    chk("a5_latency", last_valid_cyc - start_cyc, 154);
    chk("a5_data", int'(bus.uart_rx_data), 'hA5);
    chk("a5_valid_count", vcnt, 1);
    chk("a5_frame_err", fcnt, 0);

    // Back-to-back random bytes.
    rx_q.delete();
    v0 = vcnt;
    for (int i = 0; i < 20; i++) begin
      rb = PB'($urandom);
      sent_q.push_back(rb);
      send_frame(rb, 1'b1, int'($urandom_range(0, 2)));
    end
    drive(1'b1, 30);
    chk("b2b_count", vcnt - v0, 20);
    chk("b2b_frame_err", fcnt, 0);
    for (int i = 0; i < 20; i++) begin
      if (i < rx_q.size()) chk($sformatf("b2b_byte%0d", i), int'(rx_q[i]), int'(sent_q[i]));
      else chk($sformatf("b2b_missing%0d", i), 0, 1);
    end

    // Glitch shorter than half a bit, then a normal frame.
    v0 = vcnt; f0 = fcnt;
    drive(1'b0, 4);
    drive(1'b1, 200);
    chk("glitch_valid", vcnt - v0, 0);
    chk("glitch_ferr", fcnt - f0, 0);
    send_frame(8'h81, 1'b1, 20);
    chk("post_glitch_data", int'(bus.uart_rx_data), 'h81);

    // Stop bit low: frame error only, data retained.
    v0 = vcnt; f0 = fcnt; b0 = bcnt;
    send_frame(8'h3C, 1'b0, 0);
    drive(1'b1, 60);
    chk("ferr_pulse", fcnt - f0, 1);
    chk("ferr_no_break", bcnt - b0, 0);
    chk("ferr_no_valid", vcnt - v0, 0);
    chk("ferr_data_kept", int'(bus.uart_rx_data), 'h81);

    // Line held low for two frame times: two break frames.
    f0 = fcnt; b0 = bcnt;
    drive(1'b0, 20 * CPB);
    drive(1'b1, 300);
    chk("break_ferr", fcnt - f0, 2);
    chk("break_count", bcnt - b0, 2);

    // Reset during the data bits of 0x55 (transmitter released too), then 0x0F.
    v0 = vcnt; f0 = fcnt;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(i[0] ? 1'b0 : 1'b1, CPB);
    bus.uart_rxd = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 200);
    chk("abort_no_valid", vcnt - v0, 0);
    chk("abort_no_ferr", fcnt - f0, 0);
    chk("abort_data_cleared", int'(bus.uart_rx_data), 0);
    send_frame(8'h0F, 1'b1, 20);
    chk("after_abort_data", int'(bus.uart_rx_data), 'h0F);
    chk("after_abort_valid", vcnt - v0, 1);

    // Random traffic with occasional bad stop bits and enable drops.
    for (int i = 0; i < 12; i++) begin
      rb = PB'($urandom);
      fork
        send_frame(rb, ($urandom_range(0, 7) != 0), int'($urandom_range(0, 3)));
        begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(5, 150)) @(posedge clk);
            #1;
            bus.uart_rx_en = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            bus.uart_rx_en = 1'b1;
          end
        end
      join
    end
    drive(1'b1, 12 * CPB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the downstream stage that consumes the serial line driven by uart_tx.
- Synchronises the asynchronous rxd pin, detects and qualifies the start bit, samples each bit at its midpoint, and presents the received byte for one clock.
- Checks the stop bit and flags framing errors and line breaks.
- Sits at the top-level pin boundary. In loopback it is wired directly to uart_tx's uart_txd.

Parameters:
- BIT_RATE, 9600: line bit rate in bits/s.
- CLK_HZ, 50000000: system clock frequency in Hz.
- PAYLOAD_BITS, 8: data bits per frame, LSB first.
- CYCLES_PER_BIT (localparam), CLK_HZ/BIT_RATE (integer division): clocks per bit; 5208 at the defaults.
- HALF_BIT (localparam), CYCLES_PER_BIT/2: 2604 at the defaults.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- uart_rxd  input  1  serial receive pin; asynchronous, idles high.
- uart_rx_en  input  1  receiver enable; low forces idle.
- uart_rx_valid  output  1  one-cycle pulse: uart_rx_data holds a good byte.
- uart_rx_data  output  PAYLOAD_BITS  last received byte.
- uart_rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- uart_rx_break  output  1  one-cycle pulse: frame error and all data bits zero.

Behaviour:
- Reset (sampled on a clk edge while reset=1):
  - state=IDLE; cycle and bit counters = 0.
  - Synchroniser flops = 1.
  - uart_rx_valid, uart_rx_frame_err, uart_rx_break = 0; uart_rx_data = 0.
  - Reset asserted mid-frame abandons the frame. No pulse is emitted.
- Input synchronisation:
  - Two-flop synchroniser on uart_rxd; rxd_s is the second flop.
  - Pin-to-FSM latency is 2 cycles. All FSM decisions use rxd_s only.
- FSM states: IDLE, START, DATA, STOP. The cycle counter is cnt, width clog2(CYCLES_PER_BIT+1).
- IDLE:
  - cnt=0.
  - If uart_rx_en=1 and rxd_s=0, go to START.
- START:
  - cnt increments each cycle.
  - When cnt==HALF_BIT-1, sample rxd_s.
    - rxd_s=0: go to DATA, cnt=0, bit_idx=0.
    - rxd_s=1: glitch, return to IDLE with no outputs.
- DATA:
  - cnt increments. When cnt==CYCLES_PER_BIT-1, shift rxd_s into the shift register MSB-side, so the first bit received ends at bit 0; set cnt=0.
  - After PAYLOAD_BITS samples, go to STOP.
- STOP:
  - When cnt==CYCLES_PER_BIT-1, sample rxd_s.
    - rxd_s=1: load uart_rx_data from the shift register and pulse uart_rx_valid for 1 cycle.
    - rxd_s=0: pulse uart_rx_frame_err. Also pulse uart_rx_break if the shift register==0. uart_rx_valid stays 0 and uart_rx_data is unchanged.
  - In both cases return to IDLE in the same transition.
  - Because the FSM leaves STOP at mid-stop-bit, the next falling edge is caught, so back-to-back frames are supported.
- Enable:
  - uart_rx_en=0 in any state forces IDLE on the next edge.
  - The partial frame is discarded and no pulses are emitted.
- Pulse timing:
  - Pulses are registered.
  - uart_rx_valid rises exactly 2 + HALF_BIT + (PAYLOAD_BITS+1)*CYCLES_PER_BIT cycles after the first clk edge that sees uart_rxd low, ±1 cycle for synchroniser phase.
- Output holding:
  - uart_rx_data holds its value until the next valid frame.
  - Pulse outputs are never high for more than 1 cycle.
- No overrun handling: the consumer must accept the byte in the valid cycle.

Test Plan:
- Loopback with uart_tx at defaults, uart_rx_en=1, send 0xA5:
  - one uart_rx_valid pulse, uart_rx_data=8'hA5;
  - pulse occurs 2+2604+9*5208=49478 cycles ±1 after the start edge;
  - frame_err=0.
- 20 back-to-back $random bytes via uart_tx: 20 valid pulses, data matches the sent sequence in order, no frame_err.
- Glitch: drive uart_rxd low for 1000 ns (50 cycles), then high: no valid, no frame_err, FSM back in IDLE.
- Manually bit-banged 0x3C with the stop bit held low, line then released high: frame_err pulses once, valid=0, break=0, uart_rx_data unchanged.
- Line held low for 2 frame times: frame_err=1 and break=1 in the same single cycle, valid=0.
- Assert reset for 1 cycle midway through the data bits of 0x55, then send 0x0F: no pulse for the aborted frame; the next frame yields valid with data 8'h0F.
